// File: rtl/led_pwm_driver.sv
// led_pwm_driver
//   Turns the CPU's 32-bit output port into eight PWM-driven LEDs. Each 4-bit
//   field of level_in is a brightness level 0..LMAX. A PWM period is LMAX steps
//   of PRESCALE clocks each. Levels are captured only at period boundaries, so
//   a waveform is never cut short or stretched mid-period.
//
//   Build option: define LED_PWM_DRIVER_FADE_EN to make each channel walk one
//   level per period toward its target instead of jumping straight to it.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   enable        1 = run PWM; 0 = LEDs dark, prescaler and phase held at 0
//   level_in      CHANNELS x WIDTH_LEVEL target levels, channel i at [i*W +: W]
//   led           registered PWM outputs, one per channel
//   period_start  registered one-clock pulse after each period boundary
module led_pwm_driver #(
  parameter int CHANNELS    = 8,
  parameter int WIDTH_LEVEL = 4,
  parameter int PRESCALE    = 256
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [CHANNELS*WIDTH_LEVEL-1:0] level_in,
  output logic [CHANNELS-1:0]             led,
  output logic                            period_start
);

  localparam int LMAX = (1 << WIDTH_LEVEL) - 1;
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]          PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH_LEVEL-1:0] PHASE_LAST    = WIDTH_LEVEL'(LMAX - 1);

  logic [PW-1:0]          prescale_cnt;
  logic [WIDTH_LEVEL-1:0] phase;
  logic [WIDTH_LEVEL-1:0] active [CHANNELS];
  logic [WIDTH_LEVEL-1:0] target [CHANNELS];
  logic                   tick;
  logic                   boundary;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_target
      assign target[g] = level_in[g*WIDTH_LEVEL +: WIDTH_LEVEL];
    end
  endgenerate

  assign tick     = enable && (prescale_cnt == PRESCALE_LAST);
  assign boundary = tick && (phase == PHASE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_cnt <= '0;
    end else if (!enable || tick) begin
      prescale_cnt <= '0;
    end else begin
      prescale_cnt <= prescale_cnt + 1'b1;
    end
  end

  // phase stops at LMAX-1: a level of LMAX is then always above phase
  // (always on) and level 0 never is (always off).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (!enable || boundary) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + 1'b1;
    end
  end

  // Levels are sampled only on the boundary clock, including a level_in
  // change that lands in that very cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= '0;
      end
    end else if (boundary) begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef LED_PWM_DRIVER_FADE_EN
        // Only step when unequal, so active never leaves 0..LMAX.
        if (target[i] > active[i]) begin
          active[i] <= active[i] + 1'b1;
        end else if (target[i] < active[i]) begin
          active[i] <= active[i] - 1'b1;
        end
`else
        active[i] <= target[i];
`endif
      end
    end
  end

  // One register stage behind phase/active: the clock after a boundary still
  // shows the last step of the previous period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led          <= '0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        led[i] <= enable && (active[i] > phase);
      end
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
module tb_led_pwm_driver;

  localparam int CH       = 8;
  localparam int WL       = 4;
  localparam int PRESCALE = 4;
  localparam int LMAX     = 15;
  localparam int PERIOD   = PRESCALE * LMAX;
`ifdef LED_PWM_DRIVER_FADE_EN
  localparam int SETTLE = 16;
`else
  localparam int SETTLE = 1;
`endif

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        enable   = 1'b0;
  logic [31:0] level_in = '0;
  logic [7:0]  led;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  // Reference model: clock count since the PWM was (re)started; position in
  // the period and the PWM step are plain arithmetic on that count.
  int         m_n;
  int         m_act [CH];
  logic [7:0] m_led;
  logic       m_ps;

  led_pwm_driver #(.CHANNELS(CH), .WIDTH_LEVEL(WL), .PRESCALE(PRESCALE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .level_in     (level_in),
    .led          (led),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input logic [31:0] v, input int i);
    return int'(v[i*WL +: WL]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n <= 0;
      for (int i = 0; i < CH; i++) m_act[i] <= 0;
      m_led <= '0;
      m_ps  <= 1'b0;
    end else if (!enable) begin
      m_n   <= 0;
      m_led <= '0;
      m_ps  <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++)
        m_led[i] <= (m_act[i] > ((m_n % PERIOD) / PRESCALE));
      m_ps <= ((m_n % PERIOD) == PERIOD - 1);
      if ((m_n % PERIOD) == PERIOD - 1) begin
        for (int i = 0; i < CH; i++) begin
`ifdef LED_PWM_DRIVER_FADE_EN
          if (lvl(level_in, i) > m_act[i]) m_act[i] <= m_act[i] + 1;
          else if (lvl(level_in, i) < m_act[i]) m_act[i] <= m_act[i] - 1;
`else
          m_act[i] <= lvl(level_in, i);
`endif
        end
      end
      m_n <= m_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("led_vs_model", {24'd0, led}, {24'd0, m_led});
    chk("period_start_vs_model", {31'd0, period_start}, {31'd0, m_ps});
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 200);
    if (!period_start) chk("period_start_timeout", {31'd0, period_start}, 32'd1);
  endtask

  // One full period: the 60 samples after a boundary are phases 0..14 of the
  // new period, and the last sample carries the next period_start pulse.
  task automatic window(output int highs, output logic first);
    highs = 0;
    first = 1'b0;
    for (int k = 0; k < PERIOD; k++) begin
      step();
      if (k == 0) first = led[0];
      if (led[0]) highs++;
      chk("window_ps", {31'd0, period_start}, (k == PERIOD - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int   n, h0, h7, hmid, nps, hw;
    logic first, any;

    repeat (3) step();
    chk("reset_led", {24'd0, led}, 32'd0);
    chk("reset_ps", {31'd0, period_start}, 32'd0);
    reset_n = 1'b1;

    // Steady pattern: ch0 level 5, ch7 level 15, others 0.
    enable   = 1'b1;
    level_in = 32'hF000_0005;
    repeat (PERIOD * SETTLE) step();
    h0 = 0; h7 = 0; hmid = 0; nps = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      step();
      if (led[0]) h0++;
      if (led[7]) h7++;
      if (led[6:1] != 6'd0) hmid++;
      if (period_start) nps++;
    end
    chk("ch0_high_count", h0, 3 * 20);
    chk("ch7_high_count", h7, 3 * PERIOD);
    chk("ch1_6_high_count", hmid, 0);
    chk("ps_pulses", nps, 3);

    // ch0 0 -> 15 at clock 10 of a period: first effect 1 clock after the
    // next boundary, i.e. 51 clocks later.
    level_in = 32'hF000_0000;
    repeat (SETTLE + 5) wait_ps(n);
    repeat (10) step();
    level_in = 32'hF000_000F;
    n = 0;
    do begin
      step();
      n++;
    end while (!led[0] && n < 200);
    chk("rise_latency", n, 51);

    wait_ps(n);
    for (int w = 1; w <= 14; w++) begin
      window(hw, first);
`ifdef LED_PWM_DRIVER_FADE_EN
      chk("ramp_up_highs", hw, 4 * (w + 1));
`else
      chk("ramp_up_highs", hw, PERIOD);
`endif
    end
    level_in = 32'hF000_0003;
    for (int w = 1; w <= 13; w++) begin
      window(hw, first);
`ifdef LED_PWM_DRIVER_FADE_EN
      chk("ramp_down_highs", hw, 4 * (16 - w));
`else
      chk("ramp_down_highs", hw, (w == 1) ? PERIOD : 12);
`endif
    end

    // Enable dropped mid-period, then restored: pattern restarts at phase 0.
    repeat ($urandom_range(5, 50)) step();
    enable = 1'b0;
    step();
    chk("disable_led", {24'd0, led}, 32'd0);
    repeat (7) step();
    enable = 1'b1;
    window(hw, first);
    chk("reenable_first", {31'd0, first}, 32'd1);
    chk("reenable_highs", hw, 12);

    // Asynchronous reset mid-period.
    repeat ($urandom_range(3, 40)) step();
    chk("pre_reset_led7", {31'd0, led[7]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_led", {24'd0, led}, 32'd0);
    chk("async_reset_ps", {31'd0, period_start}, 32'd0);
    level_in = $urandom;
    step();
    reset_n = 1'b1;
    n   = 0;
    any = 1'b0;
    do begin
      step();
      n++;
      if (led != 8'd0) any = 1'b1;
    end while (!period_start && n < 200);
    chk("first_ps_after_reset", n, PERIOD);
    chk("dark_after_reset", {31'd0, any}, 32'd0);

    // Random levels with occasional enable toggles, checked every clock.
    for (int it = 0; it < 12; it++) begin
      level_in = $urandom;
      if ($urandom_range(0, 3) == 0) enable = ~enable;
      if (it == 11) enable = 1'b1;
      repeat ($urandom_range(20, 150)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
